// File: rtl/cred_scan_ctrl.sv
// cred_scan_ctrl: scans user/pass ROMs for a latched credential, reports grant/deny and counts failures (lockout via CRED_LOCKOUT_EN)
module cred_scan_ctrl #(
  parameter int USER_W      = 16,
  parameter int PASS_W      = 20,
  parameter int ADDR_W      = 8,
  parameter int NUM_ENTRIES = 8,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              logout,
  input  logic [USER_W-1:0] user_id,
  input  logic [PASS_W-1:0] pass_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [USER_W-1:0] rom_user_data,
  input  logic [PASS_W-1:0] rom_pass_data,
  output logic              busy,
  output logic              done,
  output logic              granted,
  output logic              user_hit,
  output logic [ADDR_W-1:0] entry_idx,
  output logic [3:0]        fail_cnt,
  output logic              locked
);
  typedef enum logic [2:0] {IDLE, SCAN_WAIT, SCAN_CMP, RESULT
`ifdef CRED_LOCKOUT_EN
    , LOCKED
`endif
  } state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ENTRIES - 1);
  state_t state;
  logic [USER_W-1:0] user_q;
  logic [PASS_W-1:0] pass_q;
`ifdef CRED_LOCKOUT_EN
  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  logic [LCW-1:0] lock_cnt;
`else
  assign locked = 1'b0 && (MAX_FAIL + LOCK_CYCLES > 0);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      user_q    <= '0;
      pass_q    <= '0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      granted   <= 1'b0;
      user_hit  <= 1'b0;
      entry_idx <= '0;
      fail_cnt  <= '0;
`ifdef CRED_LOCKOUT_EN
      locked    <= 1'b0;
      lock_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start && !locked) begin
            user_q    <= user_id;
            pass_q    <= pass_in;
            rom_addr  <= '0;
            busy      <= 1'b1;
            granted   <= 1'b0;
            user_hit  <= 1'b0;
            entry_idx <= '0;
            state     <= SCAN_WAIT;
          end else if (logout) begin
            granted <= 1'b0;
          end
        SCAN_WAIT: state <= SCAN_CMP;
        SCAN_CMP:
          if (rom_user_data == user_q) begin
            user_hit  <= 1'b1;
            entry_idx <= rom_addr;
            granted   <= rom_pass_data == pass_q;
            state     <= RESULT;
          end else if (rom_addr == LAST) begin
            state <= RESULT;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= SCAN_WAIT;
          end
        RESULT: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (granted) begin
            fail_cnt <= '0;
          end else begin
            fail_cnt <= (fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1;
`ifdef CRED_LOCKOUT_EN
            if (int'(fail_cnt) + 1 >= MAX_FAIL) begin
              locked   <= 1'b1;
              lock_cnt <= '0;
              state    <= LOCKED;
            end
`endif
          end
        end
`ifdef CRED_LOCKOUT_EN
        LOCKED:
          if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
            locked   <= 1'b0;
            fail_cnt <= '0;
            state    <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cred_scan_ctrl.sv
// tb_cred_scan_ctrl: randomized lookups against a first-match ROM reference model
module tb_cred_scan_ctrl;
  localparam int UW = 16, PW = 20, AW = 8, NE = 8, MF = 3, LC = 10;
  logic clk = 1'b0, rst, start, logout;
  logic [UW-1:0] user_id, rom_user_data;
  logic [PW-1:0] pass_in, rom_pass_data;
  logic [AW-1:0] rom_addr, entry_idx;
  logic busy, done, granted, user_hit, locked;
  logic [3:0] fail_cnt;
  logic [UW-1:0] urom [256];
  logic [PW-1:0] prom [256];
  int total = 0, bad = 0;
  int m_fail = 0, m_idx = 0;
  logic m_gr = 1'b0, m_hit = 1'b0;

  cred_scan_ctrl #(.USER_W(UW), .PASS_W(PW), .ADDR_W(AW), .NUM_ENTRIES(NE),
                   .MAX_FAIL(MF), .LOCK_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .start(start), .logout(logout), .user_id(user_id),
    .pass_in(pass_in), .rom_addr(rom_addr), .rom_user_data(rom_user_data),
    .rom_pass_data(rom_pass_data), .busy(busy), .done(done), .granted(granted),
    .user_hit(user_hit), .entry_idx(entry_idx), .fail_cnt(fail_cnt), .locked(locked));

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_user_data <= urom[rom_addr];
    rom_pass_data <= prom[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [UW-1:0] u, input logic [PW-1:0] p, input bit poke);
    int exp_lat, n, idx;
    bit hit;
    hit = 0;
    idx = 0;
    for (int i = 0; i < NE; i++)
      if (!hit && urom[i] == u) begin
        hit = 1;
        idx = i;
      end
    exp_lat = hit ? 2 * idx + 3 : 2 * NE + 1;
    m_hit = hit;
    m_idx = hit ? idx : 0;
    m_gr = hit && (prom[idx] == p);
    m_fail = m_gr ? 0 : (m_fail == 15 ? 15 : m_fail + 1);
    user_id = u;
    pass_in = p;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    check("busy_start", busy, 1);
    check("gr_clr", granted, 0);
    if (poke) begin
      user_id = ~u;
      pass_in = ~p;
      start = 1'b1;
      tick;
      start = 1'b0;
      n++;
    end
    while (!done && n < 100) begin
      tick;
      n++;
    end
    check("latency", n, exp_lat);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("granted", granted, m_gr);
    check("user_hit", user_hit, m_hit);
    check("entry_idx", entry_idx, m_idx);
    check("fail_cnt", fail_cnt, m_fail);
    check("rom_addr", rom_addr, hit ? idx : NE - 1);
`ifdef CRED_LOCKOUT_EN
    if (!m_gr && m_fail >= MF) begin
      int lc;
      lc = 1;
      check("locked", locked, 1);
      user_id = 16'h1234;
      pass_in = 20'hABCDE;
      start = 1'b1;
      for (int k = 0; k < 100; k++) begin
        tick;
        if (!locked) break;
        lc++;
        check("lock_busy", busy, 0);
      end
      start = 1'b0;
      check("lock_len", lc, LC);
      check("lock_fail", fail_cnt, 0);
      m_fail = 0;
    end else begin
      check("locked", locked, 0);
    end
`else
    check("locked", locked, 0);
`endif
    tick;
    check("done_pulse", done, 0);
  endtask

  task automatic do_logout;
    logout = 1'b1;
    tick;
    logout = 1'b0;
    check("logout_gr", granted, 0);
    check("logout_hit", user_hit, m_hit);
    check("logout_idx", entry_idx, m_idx);
    m_gr = 1'b0;
  endtask

  initial begin
    int d, j;
    logic [UW-1:0] u;
    logic [PW-1:0] p;
    for (int i = 0; i < 256; i++) begin
      do urom[i] = UW'($urandom_range(0, 16'hFFFE)); while (urom[i] == 16'h1234);
      prom[i] = PW'($urandom);
    end
    urom[3] = 16'h1234; prom[3] = 20'hABCDE;
    urom[6] = 16'h1234; prom[6] = 20'h55555;
    urom[8] = 16'hFFFF;
    rst = 1'b1; start = 1'b0; logout = 1'b0; user_id = '0; pass_in = '0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gr", granted, 0);
    check("rst_hit", user_hit, 0);
    check("rst_idx", entry_idx, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_lock", locked, 0);

    lookup(16'h1234, 20'hABCDE, 0);
    do_logout;
    lookup(16'h1234, 20'hABCDF, 0);
    lookup(16'hFFFF, 20'h0, 1);
    lookup(16'h1234, 20'h55555, 0);
    lookup(16'h1234, 20'hABCDE, 0);

    user_id = 16'h1234;
    pass_in = 20'hABCDE;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_addr", rom_addr, 0);
    check("mid_busy", busy, 0);
    check("mid_gr", granted, 0);
    check("mid_hit", user_hit, 0);
    check("mid_idx", entry_idx, 0);
    check("mid_fail", fail_cnt, 0);
    check("mid_lock", locked, 0);
    d = 0;
    repeat (12) begin
      tick;
      d += int'(done);
    end
    check("mid_nodone", d, 0);
    m_fail = 0; m_gr = 0; m_hit = 0; m_idx = 0;

    repeat (16) lookup(16'hFFFF, 20'h1, 0);

    repeat (40) begin
      j = $urandom_range(0, NE - 1);
      u = ($urandom_range(0, 3) == 0) ? UW'($urandom) : urom[j];
      p = ($urandom_range(0, 1) == 0) ? prom[j] : PW'($urandom);
      lookup(u, p, $urandom_range(0, 3) == 0);
      if (m_gr && $urandom_range(0, 2) == 0) do_logout;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
